seg_label_sink: RTL and testbench
=================================

Name: seg_label_sink

Overview:
Terminal consumer of the fixed-point feature-map stream emitted by the CNN layer chain. Per enabled pixel it:
- takes the argmax over the UNITS class scores;
- converts the winning score to a uint8 confidence;
- writes {label, confidence} into a frame buffer at the raster address given by vcnt/hcnt.
It also checks raster continuity and signals frame completion to the host-side frame reader.

Parameters:
W_HEIGHT, -1, window height in pixels; vcnt range 0..W_HEIGHT-1
W_WIDTH, -1, window width in pixels; hcnt range 0..W_WIDTH-1
UNITS, 12, class scores per pixel
INT_BITW, 5, integer bits of each signed score (sign included)
FRAC_BITW, 8, fractional bits of each score
UINT_BITW, 8, confidence output width; must equal FRAC_BITW

Ports:
clock  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_enable  in  1  pixel valid
in_y  in  [0:(INT_BITW+FRAC_BITW)*UNITS-1]  scores, unit 0 at bit 0 end, two's complement
in_vcnt  in  log2(W_HEIGHT)  row of in_y
in_hcnt  in  log2(W_WIDTH)  column of in_y
wr_en  out  1  frame-buffer write strobe
wr_addr  out  log2(W_HEIGHT*W_WIDTH)  vcnt*W_WIDTH+hcnt
wr_label  out  log2(UNITS)  argmax index
wr_conf  out  UINT_BITW  confidence
frame_done  out  1  one-cycle pulse with write of last pixel
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
seq_err  out  1  sticky raster error flag

Behaviour:
- Reset (async, rst=1): all pipeline valids 0; wr_en=0, wr_addr=0, wr_label=0, wr_conf=0, frame_done=0, frame_cnt=0, seq_err=0; FSM=WAIT_SOF. Reset mid-frame discards in-flight pixels; no partial frame_done.
- Pipeline, fully registered, accepts one pixel per cycle, no backpressure. in_enable=0 cycles are bubbles.
- Argmax latency is 4 cycles:
  - tree 12->6->3->2->1;
  - compare is signed;
  - a tie selects the lower index.
- Confidence is computed on stage 5:
  - winning score negative -> 0;
  - winning score >= 1.0 (any integer bit set) -> 2^UINT_BITW-1;
  - otherwise the FRAC_BITW low bits.
- Latency from in_enable to wr_en is 5 cycles, fixed.
- Address: vcnt*W_WIDTH+hcnt, computed alongside and delayed to match stage 5.
- Raster FSM (evaluated at input, decision carried down the pipeline as a keep bit):
  - WAIT_SOF: enabled pixel at (0,0) -> ACTIVE with expected=(0,1), kept; any other enabled pixel dropped, no error.
  - ACTIVE, enabled pixel equal to expected: kept; expected advances with hcnt wrapping at W_WIDTH-1 and vcnt incrementing.
  - ACTIVE, enabled pixel at (W_HEIGHT-1,W_WIDTH-1) and expected: kept, tagged last -> WAIT_SOF.
  - ACTIVE, unexpected pixel at (0,0): seq_err set; treated as a new SOF (kept, expected=(0,1)).
  - ACTIVE, unexpected pixel at any other position: seq_err set; pixel dropped; -> WAIT_SOF.
- A dropped pixel yields no wr_en 5 cycles later.
- frame_done is asserted with wr_en of the last-tagged pixel; frame_cnt increments the same cycle.
- seq_err is cleared only by reset.
- W_HEIGHT*W_WIDTH=1: every (0,0) pixel is both SOF and last.

Decomposition:
- Shared package: score width, label width log2(UNITS), address width, the log2 helper function, the FSM state encoding.
- One sub-module: argmax_tree (UNITS, score width; 4-stage registered signed argmax with lower-index tie-break; outputs index and value), reusable by other classification heads.
- FSM, confidence conversion and address path stay in seg_label_sink.

Test Plan:
- W_HEIGHT=2, W_WIDTH=3, six consecutive pixels, unit 7 = +0.5 (0x0080), others -1.0 -> wr_en at cycles 5..10, addrs 0..5, label 7, conf 128, frame_done with addr 5, frame_cnt=1.
- Scores for units 2 and 9 both 0x0100, rest 0 -> label 2, conf 255; max score -0x0001 for every unit -> label 0, conf 0.
- Same frame with in_enable low every other cycle -> writes spaced equally, same data, one frame_done.
- Stream starting at (0,1) then a full frame -> first pixel dropped silently, seq_err=0, full frame written.
- Frame skipping (0,2) -> seq_err=1 sticky, pixels until the next (0,0) not written, no frame_done; the following full frame completes, frame_cnt=1.
- rst pulsed after 3 pixels of a frame -> no wr_en for in-flight pixels, all outputs 0, the next full frame gives frame_cnt=1.

Source files
------------

// File: rtl/seg_label_sink_pkg.sv
// Shared types, default widths and width helpers for the segmentation label sink
// and any other classification heads that reuse the argmax tree.
package seg_label_sink_pkg;

  // Width in bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int log2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Number of pairwise reduction levels needed to bring n candidates down to one.
  function automatic int tree_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 1) begin
      c = (c + 1) / 2;
      l++;
    end
    return l;
  endfunction

  // Number of surviving candidates after lvl reduction levels.
  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Frame-buffer address width for a window of h rows by w columns.
  function automatic int addr_width(input int h, input int w);
    return log2w(h * w);
  endfunction

  localparam int UNITS_DEF     = 12;
  localparam int INT_BITW_DEF  = 5;
  localparam int FRAC_BITW_DEF = 8;
  localparam int UINT_BITW_DEF = 8;
  localparam int SCORE_W_DEF   = INT_BITW_DEF + FRAC_BITW_DEF;
  localparam int LABEL_W_DEF   = log2w(UNITS_DEF);

  // Raster tracker states: waiting for the top-left pixel, or inside a frame.
  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } raster_state_t;

endpackage

// File: rtl/seg_label_sink_argmax_tree.sv
// Registered signed argmax over UNITS scores. Each tree level halves the number
// of candidates (rounding up) and costs one clock; on equal scores the lower
// index wins so results are deterministic.
module argmax_tree
  import seg_label_sink_pkg::*;
#(
  parameter int  UNITS   = UNITS_DEF,
  parameter int  SCORE_W = SCORE_W_DEF,
  localparam int IDX_W   = log2w(UNITS),
  localparam int LEVELS  = tree_levels(UNITS)
) (
  input  logic                       clock,
  input  logic [SCORE_W*UNITS-1:0]   scores,
  output logic [IDX_W-1:0]           max_index,
  output logic signed [SCORE_W-1:0]  max_value
);

  // Level 0 is the raw input; levels 1..LEVELS are the pipeline registers.
  // The combinational view is padded to 2*UNITS so pair lookups stay in range.
  logic signed [SCORE_W-1:0] lvl_val [0:LEVELS][0:2*UNITS-1];
  logic        [IDX_W-1:0]   lvl_idx [0:LEVELS][0:2*UNITS-1];
  logic signed [SCORE_W-1:0] reg_val [1:LEVELS][0:UNITS-1];
  logic        [IDX_W-1:0]   reg_idx [1:LEVELS][0:UNITS-1];

  // Present inputs and registered levels as one uniform array for the reducer.
  always_comb begin
    for (int l = 0; l <= LEVELS; l++) begin
      for (int i = 0; i < 2 * UNITS; i++) begin
        lvl_val[l][i] = '0;
        lvl_idx[l][i] = '0;
      end
    end
    for (int i = 0; i < UNITS; i++) begin
      lvl_val[0][i] = scores[i*SCORE_W +: SCORE_W];
      lvl_idx[0][i] = IDX_W'(i);
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int i = 0; i < UNITS; i++) begin
        lvl_val[l][i] = reg_val[l][i];
        lvl_idx[l][i] = reg_idx[l][i];
      end
    end
  end

  // Each level keeps the larger of a pair; the upper candidate must be strictly
  // greater to win, and an odd leftover passes through unchanged.
  always_ff @(posedge clock) begin
    for (int l = 1; l <= LEVELS; l++) begin
      for (int i = 0; i < UNITS; i++) begin
        if ((2 * i + 1 < level_count(UNITS, l - 1)) &&
            (lvl_val[l-1][2*i+1] > lvl_val[l-1][2*i])) begin
          reg_val[l][i] <= lvl_val[l-1][2*i+1];
          reg_idx[l][i] <= lvl_idx[l-1][2*i+1];
        end else begin
          reg_val[l][i] <= lvl_val[l-1][2*i];
          reg_idx[l][i] <= lvl_idx[l-1][2*i];
        end
      end
    end
  end

  assign max_index = reg_idx[LEVELS][0];
  assign max_value = reg_val[LEVELS][0];

endmodule

// File: rtl/seg_label_sink.sv
// Terminal sink of the CNN feature-map stream: per kept pixel it writes the
// argmax label and a uint8 confidence into the frame buffer, tracks raster
// continuity and pulses frame_done with the write of the last pixel.
module seg_label_sink
  import seg_label_sink_pkg::*;
#(
  parameter int  W_HEIGHT  = 2,
  parameter int  W_WIDTH   = 3,
  parameter int  UNITS     = UNITS_DEF,
  parameter int  INT_BITW  = INT_BITW_DEF,
  parameter int  FRAC_BITW = FRAC_BITW_DEF,
  parameter int  UINT_BITW = UINT_BITW_DEF,
  localparam int SCORE_W   = INT_BITW + FRAC_BITW,
  localparam int LABEL_W   = log2w(UNITS),
  localparam int VCNT_W    = log2w(W_HEIGHT),
  localparam int HCNT_W    = log2w(W_WIDTH),
  localparam int ADDR_W    = addr_width(W_HEIGHT, W_WIDTH)
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         in_enable,
  input  logic [0:SCORE_W*UNITS-1]     in_y,
  input  logic [VCNT_W-1:0]            in_vcnt,
  input  logic [HCNT_W-1:0]            in_hcnt,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [LABEL_W-1:0]           wr_label,
  output logic [UINT_BITW-1:0]         wr_conf,
  output logic                         frame_done,
  output logic [15:0]                  frame_cnt,
  output logic                         seq_err
);

  localparam int LEVELS = tree_levels(UNITS);

  // Side information travelling alongside the argmax tree.
  typedef struct packed {
    logic              keep;
    logic              last;
    logic [ADDR_W-1:0] addr;
  } meta_t;

  raster_state_t               state;
  logic [VCNT_W-1:0]           exp_v;
  logic [HCNT_W-1:0]           exp_h;
  logic [VCNT_W-1:0]           adv_v;
  logic [HCNT_W-1:0]           adv_h;
  logic                        at_origin;
  logic                        at_last;
  logic                        is_expected;
  logic [ADDR_W-1:0]           pixel_addr;
  logic [SCORE_W*UNITS-1:0]    scores_flat;
  logic [LABEL_W-1:0]          win_idx;
  logic signed [SCORE_W-1:0]   win_val;
  logic [UINT_BITW-1:0]        conf;
  meta_t                       s1;
  meta_t                       dly [0:LEVELS-2];
  meta_t                       s4;

  // Repack the score bus so unit u sits at bits u*SCORE_W upward.
  always_comb begin
    scores_flat = '0;
    for (int u = 0; u < UNITS; u++) begin
      scores_flat[u*SCORE_W +: SCORE_W] = in_y[u*SCORE_W +: SCORE_W];
    end
  end

  argmax_tree #(
    .UNITS   (UNITS),
    .SCORE_W (SCORE_W)
  ) u_argmax (
    .clock     (clock),
    .scores    (scores_flat),
    .max_index (win_idx),
    .max_value (win_val)
  );

  // Position classification of the incoming pixel and the raster successor of it.
  always_comb begin
    at_origin   = (in_vcnt == '0) && (in_hcnt == '0);
    at_last     = (in_vcnt == VCNT_W'(W_HEIGHT - 1)) && (in_hcnt == HCNT_W'(W_WIDTH - 1));
    is_expected = (in_vcnt == exp_v) && (in_hcnt == exp_h);
    pixel_addr  = ADDR_W'(in_vcnt) * ADDR_W'(W_WIDTH) + ADDR_W'(in_hcnt);
    if (in_hcnt == HCNT_W'(W_WIDTH - 1)) begin
      adv_h = '0;
      adv_v = in_vcnt + VCNT_W'(1);
    end else begin
      adv_h = in_hcnt + HCNT_W'(1);
      adv_v = in_vcnt;
    end
  end

  // Raster tracker: decides keep/last per pixel and latches the sticky error.
  // A kept pixel always advances the expectation from its own position, which
  // covers both the in-order case and a restart at (0,0).
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= WAIT_SOF;
      exp_v   <= '0;
      exp_h   <= '0;
      s1      <= '0;
      seq_err <= 1'b0;
    end else begin
      s1.keep <= 1'b0;
      s1.last <= 1'b0;
      s1.addr <= pixel_addr;
      if (in_enable) begin
        case (state)
          WAIT_SOF: begin
            if (at_origin) begin
              s1.keep <= 1'b1;
              s1.last <= at_last;
              state   <= at_last ? WAIT_SOF : ACTIVE;
              exp_v   <= adv_v;
              exp_h   <= adv_h;
            end
          end
          ACTIVE: begin
            if (is_expected) begin
              s1.keep <= 1'b1;
              s1.last <= at_last;
              state   <= at_last ? WAIT_SOF : ACTIVE;
              exp_v   <= adv_v;
              exp_h   <= adv_h;
            end else if (at_origin) begin
              seq_err <= 1'b1;
              s1.keep <= 1'b1;
              s1.last <= at_last;
              state   <= at_last ? WAIT_SOF : ACTIVE;
              exp_v   <= adv_v;
              exp_h   <= adv_h;
            end else begin
              seq_err <= 1'b1;
              state   <= WAIT_SOF;
            end
          end
          default: state <= WAIT_SOF;
        endcase
      end
    end
  end

  // Delay the side information so it lines up with the tree output.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS - 2; k++) dly[k] <= '0;
    end else begin
      dly[0] <= s1;
      for (int k = 1; k <= LEVELS - 2; k++) dly[k] <= dly[k-1];
    end
  end

  assign s4 = dly[LEVELS-2];

  // Saturating conversion of the winning fixed-point score to an unsigned byte.
  always_comb begin
    if (win_val[SCORE_W-1]) begin
      conf = '0;
    end else if (|win_val[SCORE_W-2:FRAC_BITW]) begin
      conf = '1;
    end else begin
      conf = win_val[FRAC_BITW-1:0];
    end
  end

  // Output stage: frame-buffer write, frame completion pulse and frame counter.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_label   <= '0;
      wr_conf    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_en      <= s4.keep;
      frame_done <= s4.keep && s4.last;
      if (s4.keep) begin
        wr_addr  <= s4.addr;
        wr_label <= win_idx;
        wr_conf  <= conf;
      end
      if (s4.keep && s4.last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_label_sink.sv
// Directed bench for seg_label_sink on a 2x3 window with 12 classes of Q5.8 scores.
module tb_seg_label_sink;
  import seg_label_sink_pkg::*;

  localparam int H  = 2;
  localparam int W  = 3;
  localparam int U  = 12;
  localparam int SW = 13;
  localparam int VW = 1;
  localparam int HW = 2;
  localparam int AW = 3;
  localparam int LW = 4;

  logic            clock = 1'b0;
  logic            rst;
  logic            in_enable;
  logic [0:SW*U-1] y_vec;
  logic [VW-1:0]   in_vcnt;
  logic [HW-1:0]   in_hcnt;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [LW-1:0]   wr_label;
  logic [7:0]      wr_conf;
  logic            frame_done;
  logic [15:0]     frame_cnt;
  logic            seq_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   cyc;
    logic en;
    int   addr;
    int   label;
    int   conf;
    logic done;
    int   fcnt;
  } rec_t;

  rec_t recs[$];

  seg_label_sink #(
    .W_HEIGHT (H),
    .W_WIDTH  (W)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .in_enable  (in_enable),
    .in_y       (y_vec),
    .in_vcnt    (in_vcnt),
    .in_hcnt    (in_hcnt),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_label   (wr_label),
    .wr_conf    (wr_conf),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .seq_err    (seq_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every write or completion pulse, sampled away from the active edge.
  always @(negedge clock) begin
    if (wr_en || frame_done) begin
      recs.push_back('{cyc, wr_en, int'(wr_addr), int'(wr_label), int'(wr_conf),
                       frame_done, int'(frame_cnt)});
    end
  end

  task automatic set_all(input logic [SW-1:0] v);
    for (int u = 0; u < U; u++) y_vec[u*SW +: SW] = v;
  endtask

  task automatic set_unit(input int u, input logic [SW-1:0] v);
    y_vec[u*SW +: SW] = v;
  endtask

  task automatic drive(input logic en, input int v, input int h);
    in_enable = en;
    in_vcnt   = VW'(v);
    in_hcnt   = HW'(h);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    in_enable = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_enable = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    recs.delete();
  endtask

  task automatic send_frame();
    for (int k = 0; k < H * W; k++) drive(1'b1, k / W, k % W);
  endtask

  task automatic basic_pattern();
    set_all(13'h1F00);
    set_unit(7, 13'h0080);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_enable = 1'b0;
    basic_pattern();
    @(negedge clock);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0b want 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_label !== '0) begin errors++; $display("[TB] FAIL reset_wr_label: got %0d want 0", wr_label); end
    checks++; if (wr_conf !== '0) begin errors++; $display("[TB] FAIL reset_wr_conf: got %0d want 0", wr_conf); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %0b want 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_seq_err: got %0b want 0", seq_err); end
    rst = 1'b0;
    idle(4);
    checks++; if (recs.size() != 0) begin errors++; $display("[TB] FAIL reset_idle_writes: got %0d want 0", recs.size()); end
  endtask

  task automatic test_basic_frame();
    int start;
    do_reset();
    basic_pattern();
    start = cyc;
    send_frame();
    idle(8);
    checks++; if (recs.size() != 6) begin errors++; $display("[TB] FAIL basic_count: got %0d want 6", recs.size()); end
    for (int k = 0; k < recs.size() && k < 6; k++) begin
      checks++; if (recs[k].cyc != start + 5 + k) begin errors++; $display("[TB] FAIL basic_cycle[%0d]: got %0d want %0d", k, recs[k].cyc, start + 5 + k); end
      checks++; if (recs[k].en !== 1'b1) begin errors++; $display("[TB] FAIL basic_en[%0d]: got %0b want 1", k, recs[k].en); end
      checks++; if (recs[k].addr != k) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %0d want %0d", k, recs[k].addr, k); end
      checks++; if (recs[k].label != 7) begin errors++; $display("[TB] FAIL basic_label[%0d]: got %0d want 7", k, recs[k].label); end
      checks++; if (recs[k].conf != 128) begin errors++; $display("[TB] FAIL basic_conf[%0d]: got %0d want 128", k, recs[k].conf); end
      checks++; if (recs[k].done !== (k == 5)) begin errors++; $display("[TB] FAIL basic_done[%0d]: got %0b want %0b", k, recs[k].done, k == 5); end
      checks++; if (recs[k].fcnt != (k == 5 ? 1 : 0)) begin errors++; $display("[TB] FAIL basic_fcnt[%0d]: got %0d want %0d", k, recs[k].fcnt, k == 5 ? 1 : 0); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_seq_err: got %0b want 0", seq_err); end
  endtask

  task automatic test_argmax_conf();
    int exp_label [6];
    int exp_conf [6];
    do_reset();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin set_all(13'h0000); set_unit(2, 13'h0100); set_unit(9, 13'h0100); exp_label[k] = 2;  exp_conf[k] = 255; end
        1: begin set_all(13'h1FFF);                                               exp_label[k] = 0;  exp_conf[k] = 0;   end
        2: begin set_all(13'h1F00); set_unit(11, 13'h0040);                       exp_label[k] = 11; exp_conf[k] = 64;  end
        3: begin set_all(13'h0000); set_unit(4, 13'h0FFF);                        exp_label[k] = 4;  exp_conf[k] = 255; end
        4: begin set_all(13'h1FFF); set_unit(3, 13'h0001);                        exp_label[k] = 3;  exp_conf[k] = 1;   end
        default: begin set_all(13'h0000); set_unit(5, 13'h0081); set_unit(6, 13'h0080); exp_label[k] = 5; exp_conf[k] = 129; end
      endcase
      drive(1'b1, k / W, k % W);
    end
    idle(8);
    checks++; if (recs.size() != 6) begin errors++; $display("[TB] FAIL argmax_count: got %0d want 6", recs.size()); end
    for (int k = 0; k < recs.size() && k < 6; k++) begin
      checks++; if (recs[k].label != exp_label[k]) begin errors++; $display("[TB] FAIL argmax_label[%0d]: got %0d want %0d", k, recs[k].label, exp_label[k]); end
      checks++; if (recs[k].conf != exp_conf[k]) begin errors++; $display("[TB] FAIL argmax_conf[%0d]: got %0d want %0d", k, recs[k].conf, exp_conf[k]); end
      checks++; if (recs[k].addr != k) begin errors++; $display("[TB] FAIL argmax_addr[%0d]: got %0d want %0d", k, recs[k].addr, k); end
    end
  endtask

  task automatic test_bubbles();
    int start;
    do_reset();
    basic_pattern();
    start = cyc;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, k / W, k % W);
      drive(1'b0, 0, 0);
    end
    idle(8);
    checks++; if (recs.size() != 6) begin errors++; $display("[TB] FAIL bubble_count: got %0d want 6", recs.size()); end
    for (int k = 0; k < recs.size() && k < 6; k++) begin
      checks++; if (recs[k].cyc != start + 5 + 2 * k) begin errors++; $display("[TB] FAIL bubble_cycle[%0d]: got %0d want %0d", k, recs[k].cyc, start + 5 + 2 * k); end
      checks++; if (recs[k].addr != k) begin errors++; $display("[TB] FAIL bubble_addr[%0d]: got %0d want %0d", k, recs[k].addr, k); end
      checks++; if (recs[k].label != 7 || recs[k].conf != 128) begin errors++; $display("[TB] FAIL bubble_data[%0d]: got %0d/%0d want 7/128", k, recs[k].label, recs[k].conf); end
      checks++; if (recs[k].done !== (k == 5)) begin errors++; $display("[TB] FAIL bubble_done[%0d]: got %0b want %0b", k, recs[k].done, k == 5); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL bubble_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_bad_start();
    int start;
    do_reset();
    basic_pattern();
    start = cyc;
    drive(1'b1, 0, 1);
    send_frame();
    idle(8);
    checks++; if (recs.size() != 6) begin errors++; $display("[TB] FAIL badstart_count: got %0d want 6", recs.size()); end
    for (int k = 0; k < recs.size() && k < 6; k++) begin
      checks++; if (recs[k].cyc != start + 6 + k) begin errors++; $display("[TB] FAIL badstart_cycle[%0d]: got %0d want %0d", k, recs[k].cyc, start + 6 + k); end
      checks++; if (recs[k].addr != k) begin errors++; $display("[TB] FAIL badstart_addr[%0d]: got %0d want %0d", k, recs[k].addr, k); end
    end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL badstart_seq_err: got %0b want 0", seq_err); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL badstart_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_skip();
    int start;
    int exp_cyc [8];
    int exp_addr [8];
    do_reset();
    basic_pattern();
    start = cyc;
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 1);
    drive(1'b1, 1, 0);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("[TB] FAIL skip_seq_err_set: got %0b want 1", seq_err); end
    drive(1'b1, 1, 1);
    drive(1'b1, 1, 2);
    send_frame();
    idle(8);
    exp_cyc[0] = start + 5; exp_addr[0] = 0;
    exp_cyc[1] = start + 6; exp_addr[1] = 1;
    for (int k = 0; k < 6; k++) begin
      exp_cyc[k+2]  = start + 10 + k;
      exp_addr[k+2] = k;
    end
    checks++; if (recs.size() != 8) begin errors++; $display("[TB] FAIL skip_count: got %0d want 8", recs.size()); end
    for (int k = 0; k < recs.size() && k < 8; k++) begin
      checks++; if (recs[k].cyc != exp_cyc[k]) begin errors++; $display("[TB] FAIL skip_cycle[%0d]: got %0d want %0d", k, recs[k].cyc, exp_cyc[k]); end
      checks++; if (recs[k].addr != exp_addr[k]) begin errors++; $display("[TB] FAIL skip_addr[%0d]: got %0d want %0d", k, recs[k].addr, exp_addr[k]); end
      checks++; if (recs[k].done !== (k == 7)) begin errors++; $display("[TB] FAIL skip_done[%0d]: got %0b want %0b", k, recs[k].done, k == 7); end
    end
    checks++; if (seq_err !== 1'b1) begin errors++; $display("[TB] FAIL skip_seq_err_sticky: got %0b want 1", seq_err); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL skip_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    basic_pattern();
    start = cyc;
    send_frame();
    send_frame();
    idle(8);
    checks++; if (recs.size() != 12) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 12", recs.size()); end
    for (int k = 0; k < recs.size() && k < 12; k++) begin
      checks++; if (recs[k].cyc != start + 5 + k) begin errors++; $display("[TB] FAIL b2b_cycle[%0d]: got %0d want %0d", k, recs[k].cyc, start + 5 + k); end
      checks++; if (recs[k].addr != k % 6) begin errors++; $display("[TB] FAIL b2b_addr[%0d]: got %0d want %0d", k, recs[k].addr, k % 6); end
      checks++; if (recs[k].done !== (k % 6 == 5)) begin errors++; $display("[TB] FAIL b2b_done[%0d]: got %0b want %0b", k, recs[k].done, k % 6 == 5); end
      checks++; if (recs[k].fcnt != (k + 1) / 6) begin errors++; $display("[TB] FAIL b2b_fcnt[%0d]: got %0d want %0d", k, recs[k].fcnt, (k + 1) / 6); end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    basic_pattern();
    drive(1'b1, 0, 0);
    drive(1'b1, 0, 1);
    drive(1'b1, 0, 2);
    rst       = 1'b1;
    in_enable = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_strobes: got %0b/%0b want 0/0", wr_en, frame_done); end
    checks++; if (frame_cnt !== 16'd0 || seq_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_status: got %0d/%0b want 0/0", frame_cnt, seq_err); end
    checks++; if (wr_addr !== '0 || wr_label !== '0 || wr_conf !== '0) begin errors++; $display("[TB] FAIL midrst_data: got %0d/%0d/%0d want 0/0/0", wr_addr, wr_label, wr_conf); end
    repeat (2) @(negedge clock);
    rst = 1'b0;
    idle(8);
    checks++; if (recs.size() != 0) begin errors++; $display("[TB] FAIL midrst_inflight: got %0d writes want 0", recs.size()); end
    send_frame();
    idle(8);
    checks++; if (recs.size() != 6) begin errors++; $display("[TB] FAIL midrst_count: got %0d want 6", recs.size()); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL midrst_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_seq_err: got %0b want 0", seq_err); end
  endtask

  // Scenario sequence; every wait is a fixed cycle count so the run always ends.
  initial begin
    rst       = 1'b1;
    in_enable = 1'b0;
    in_vcnt   = '0;
    in_hcnt   = '0;
    y_vec     = '0;
    test_reset();
    test_basic_frame();
    test_argmax_conf();
    test_bubbles();
    test_bad_start();
    test_skip();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
